// File: rtl/alu_mode_controller_pkg.sv
// Shared definitions for the pushbutton-driven AND/ADD mode controller.
package alu_mode_controller_pkg;

  localparam int DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_AND  = 2'b01,
    MODE_ADD  = 2'b10
  } mode_e;

endpackage

// File: rtl/alu_mode_controller_button_debouncer.sv
// Two-flop synchronizer plus counter-based debouncer for one raw pushbutton,
// emitting a single-cycle pulse when an accepted press (0->1) occurs.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_pulse
);
  import alu_mode_controller_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 meta_q;
  logic                 sync_q;
  logic                 prev_q;
  logic                 level_q, level_d;
  logic                 pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // The counter only advances while the synchronized level both disagrees
  // with the accepted level and has not moved since the previous cycle.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if ((sync_q != level_q) && (sync_q == prev_q)) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        pulse_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level       = level_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/alu_mode_controller.sv
// Latches AND/ADD mode from debounced pushbutton presses and registers the
// selected 4-bit result with carry and valid flags.
module alu_mode_controller
  import alu_mode_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  left_pushbutton,
  input  logic                  right_pushbutton,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  carry,
  output logic [1:0]            mode,
  output logic                  out_valid
);

  logic left_press, right_press;
  logic left_level_unused, right_level_unused;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_left_db (
    .clk        (clk),
    .reset      (reset),
    .raw        (left_pushbutton),
    .level      (left_level_unused),
    .press_pulse(left_press)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_right_db (
    .clk        (clk),
    .reset      (reset),
    .raw        (right_pushbutton),
    .level      (right_level_unused),
    .press_pulse(right_press)
  );

  mode_e                 mode_q, mode_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  carry_q, carry_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH:0]   sum;

  // Simultaneous presses cancel out and leave the mode untouched.
  always_comb begin
    mode_d = mode_q;
    if (left_press && !right_press) begin
      mode_d = MODE_AND;
    end else if (right_press && !left_press) begin
      mode_d = MODE_ADD;
    end
  end

  assign sum = {1'b0, A} + {1'b0, B};

  always_comb begin
    out_d   = '0;
    carry_d = 1'b0;
    valid_d = (mode_q != MODE_IDLE);
    case (mode_q)
      MODE_AND: out_d = A & B;
      MODE_ADD: {carry_d, out_d} = sum;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign mode      = mode_q;
  assign out       = out_q;
  assign carry     = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_mode_controller.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized button/operand traffic against a sliding-window reference model.
module tb_alu_mode_controller;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lp = 1'b0;
  logic       rp = 1'b0;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;
  logic [3:0] out;
  logic       carry;
  logic [1:0] mode;
  logic       out_valid;

  alu_mode_controller #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (20)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .left_pushbutton (lp),
    .right_pushbutton(rp),
    .A               (A),
    .B               (B),
    .out             (out),
    .carry           (carry),
    .mode            (mode),
    .out_valid       (out_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: raw sample history per button, accepted levels,
  // pending press events, chosen mode and the registered result.
  bit         hist_l[$];
  bit         hist_r[$];
  bit         m_lev_l, m_lev_r;
  bit         m_pulse_l, m_pulse_r;
  logic [1:0] m_mode;
  logic [3:0] m_out;
  bit         m_carry, m_valid;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist_l.delete();
    hist_r.delete();
    m_lev_l = 0; m_lev_r = 0;
    m_pulse_l = 0; m_pulse_r = 0;
    m_mode = 2'd0; m_out = 4'd0; m_carry = 0; m_valid = 0;
  endtask

  // A level is accepted once D+1 consecutive synchronized samples agree and
  // differ from the current level; synchronized sample = raw two edges back.
  function automatic int window_val(input bit q[$]);
    bit v;
    bit x;
    v = 1'b0;
    for (int k = 0; k <= D; k++) begin
      int idx;
      idx = q.size() - 3 - D + k;
      x = (idx >= 0) ? q[idx] : 1'b0;
      if (k == 0) v = x;
      else if (x != v) return -1;
    end
    return int'(v);
  endfunction

  task automatic model_edge();
    int         wl, wr;
    bit         np_l, np_r;
    logic [1:0] nm;
    logic [4:0] s;
    if (reset) begin
      model_reset();
      return;
    end
    hist_l.push_back(lp);
    hist_r.push_back(rp);
    if (hist_l.size() > D + 3) void'(hist_l.pop_front());
    if (hist_r.size() > D + 3) void'(hist_r.pop_front());
    wl = window_val(hist_l);
    wr = window_val(hist_r);
    np_l = 0; np_r = 0;
    if (wl >= 0 && wl != int'(m_lev_l)) begin np_l = (wl == 1); m_lev_l = (wl == 1); end
    if (wr >= 0 && wr != int'(m_lev_r)) begin np_r = (wr == 1); m_lev_r = (wr == 1); end
    nm = m_mode;
    if (m_pulse_l && !m_pulse_r) nm = 2'd1;
    if (m_pulse_r && !m_pulse_l) nm = 2'd2;
    s = 5'(A) + 5'(B);
    m_valid = (m_mode != 2'd0);
    if (m_mode == 2'd2) begin m_out = s[3:0]; m_carry = s[4]; end
    else if (m_mode == 2'd1) begin m_out = A & B; m_carry = 0; end
    else begin m_out = 4'd0; m_carry = 0; end
    m_mode = nm;
    m_pulse_l = np_l;
    m_pulse_r = np_r;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".out"},   8'(out),       8'(m_out));
    check({tag, ".carry"}, 8'(carry),     8'(m_carry));
    check({tag, ".mode"},  8'(mode),      8'(m_mode));
    check({tag, ".valid"}, 8'(out_valid), 8'(m_valid));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  typedef struct {
    string      name;
    bit         l;
    bit         r;
    logic [3:0] a;
    logic [3:0] b;
    int         cyc;
    logic [1:0] emode;
    logic [3:0] eout;
    bit         ecarry;
    bit         evalid;
  } vec_t;

  vec_t vecs[$];

  initial begin
    model_reset();
    vecs.push_back('{"idle",        0, 0, 4'b1100, 4'b1010,  3, 2'b00, 4'b0000, 0, 0});
    vecs.push_back('{"left_hold",   1, 0, 4'b1100, 4'b1010, 10, 2'b01, 4'b1000, 0, 1});
    vecs.push_back('{"left_rel",    0, 0, 4'b1100, 4'b1010,  8, 2'b01, 4'b1000, 0, 1});
    vecs.push_back('{"right_hold",  0, 1, 4'b1100, 4'b1010, 10, 2'b10, 4'b0110, 1, 1});
    vecs.push_back('{"right_rel",   0, 0, 4'b1100, 4'b1010,  8, 2'b10, 4'b0110, 1, 1});
    vecs.push_back('{"opnd_change", 0, 0, 4'b0001, 4'b0011,  1, 2'b10, 4'b0100, 0, 1});
    vecs.push_back('{"left_again",  1, 0, 4'b0001, 4'b0011, 10, 2'b01, 4'b0001, 0, 1});
    vecs.push_back('{"left_rel2",   0, 0, 4'b0001, 4'b0011,  8, 2'b01, 4'b0001, 0, 1});
    vecs.push_back('{"glitch",      0, 1, 4'b0001, 4'b0011,  3, 2'b01, 4'b0001, 0, 1});
    vecs.push_back('{"glitch_rel",  0, 0, 4'b0001, 4'b0011,  8, 2'b01, 4'b0001, 0, 1});
    vecs.push_back('{"both",        1, 1, 4'b0001, 4'b0011, 10, 2'b01, 4'b0001, 0, 1});
    vecs.push_back('{"both_rel",    0, 0, 4'b0001, 4'b0011,  8, 2'b01, 4'b0001, 0, 1});

    // Reset state, held across two edges.
    #1;
    compare_model("rst");
    steps(2, "rst");
    reset = 1'b0;

    for (int v = 0; v < vecs.size(); v++) begin
      lp = vecs[v].l; rp = vecs[v].r; A = vecs[v].a; B = vecs[v].b;
      steps(vecs[v].cyc, vecs[v].name);
      check({vecs[v].name, ".tbl_mode"},  8'(mode),      8'(vecs[v].emode));
      check({vecs[v].name, ".tbl_out"},   8'(out),       8'(vecs[v].eout));
      check({vecs[v].name, ".tbl_carry"}, 8'(carry),     8'(vecs[v].ecarry));
      check({vecs[v].name, ".tbl_valid"}, 8'(out_valid), 8'(vecs[v].evalid));
      $display("vec %0d %s mode=%b out=%b carry=%b valid=%b", v, vecs[v].name,
               mode, out, carry, out_valid);
    end

    // Exact latency: raw rise at edge 0, mode flips at edge 7, result at edge 8.
    rp = 1'b1;
    steps(7, "lat");
    check("lat.mode_e6", 8'(mode), 8'(2'b01));
    step("lat");
    check("lat.mode_e7", 8'(mode), 8'(2'b10));
    check("lat.out_e7",  8'(out),  8'(4'b0001));
    step("lat");
    check("lat.out_e8",   8'(out),   8'(4'b0100));
    check("lat.carry_e8", 8'(carry), 8'(1'b0));
    $display("seq latency mode=%b out=%b", mode, out);
    steps(3, "lat");
    rp = 1'b0;
    steps(8, "lat_rel");

    // Reset mid-debounce, then a still-held button must re-qualify fully.
    lp = 1'b1;
    steps(4, "rstmid");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rstmid.out_now",   8'(out),       8'(4'b0000));
    check("rstmid.mode_now",  8'(mode),      8'(2'b00));
    check("rstmid.carry_now", 8'(carry),     8'(1'b0));
    check("rstmid.valid_now", 8'(out_valid), 8'(1'b0));
    steps(2, "rstmid_hold");
    reset = 1'b0;
    steps(7, "requal");
    check("requal.mode_e6", 8'(mode), 8'(2'b00));
    step("requal");
    check("requal.mode_e7", 8'(mode), 8'(2'b01));
    step("requal");
    check("requal.valid_e8", 8'(out_valid), 8'(1'b1));
    $display("seq reset_requal mode=%b valid=%b", mode, out_valid);
    lp = 1'b0;
    steps(8, "requal_rel");

    // Randomized buttons with random hold lengths and free-running operands.
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      lp = 1'($urandom_range(0, 1));
      rp = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        A = 4'($urandom);
        B = 4'($urandom);
        step("rand");
      end
      $display("rand seg %0d l=%b r=%b len=%0d mode=%b", seg, lp, rp, len, mode);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
